galois_lfsr_gen: RTL and testbench

Parametrised Galois LFSR pseudo-random source. Width, polynomial, seed and output bits per clock are parameters, and any width from 2 to 64 is supported. Output goes through a registered valid/ready interface with backpressure. A run-time reseed port substitutes a safe seed when given zero. The block feeds test-pattern, scrambler and dither consumers on the peripheral bus side of the SoC.

---
 rtl/galois_lfsr_pkg.sv | 19 +
 rtl/galois_lfsr_step.sv | 25 ++
 rtl/galois_lfsr_gen.sv | 109 ++++++++++
 tb/tb_galois_lfsr_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galois_lfsr_pkg.sv
// Shared constants and helpers for the Galois LFSR generator and its companions.
package galois_lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 64;

  // Default primitive feedback taps, excluding the x^N term.
  localparam logic [7:0]  LFSR_POLY_8  = 8'h1D;
  localparam logic [15:0] LFSR_POLY_16 = 16'h002D;
  localparam logic [31:0] LFSR_POLY_32 = 32'h000000C5;

  // A zero state would lock the LFSR, so a zero seed is replaced by the fallback.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_safe_seed(
    input logic [LFSR_MAX_WIDTH-1:0] value,
    input logic [LFSR_MAX_WIDTH-1:0] fallback
  );
    return (value == '0) ? fallback : value;
  endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// Combinational K-step Galois LFSR advance; shared with the PRBS checker.
module galois_lfsr_step
  import galois_lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(LFSR_POLY_8),
  parameter int unsigned          STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] work;

  always_comb begin
    // NOTE: blocking assignments let each loop iteration see the previous step;
    // assigning work first also gives every path a value, so no latch is inferred.
    work = state;
    for (int i = 0; i < int'(STEPS); i++) begin
      work = {work[WIDTH-2:0], 1'b0} ^ ({WIDTH{work[WIDTH-1]}} & POLY);
    end
    next_state = work;
  end

endmodule

// File: rtl/galois_lfsr_gen.sv
// Galois LFSR pseudo-random word source with valid/ready output and safe reseeding.
// Optional step counter / period detector enabled by GALOIS_LFSR_PERIOD_COUNT_EN.
module galois_lfsr_gen
  import galois_lfsr_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH                 = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY                  = LFSR_WIDTH'(LFSR_POLY_8),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED                  = LFSR_WIDTH'(1),
  parameter int unsigned           LFSR_OUTPUT_BITS_PER_CLOCK = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  seed_load,
  input  logic [LFSR_WIDTH-1:0]                 seed_value,
  output logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] lfsr_out,
  output logic                                  lfsr_valid,
  input  logic                                  lfsr_ready,
  output logic                                  seed_zero_err
`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
  ,
  output logic [LFSR_WIDTH-1:0]                 step_count,
  output logic                                  period_wrap
`endif
);

  localparam int unsigned K = LFSR_OUTPUT_BITS_PER_CLOCK;

  if (LFSR_WIDTH < 2 || LFSR_WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("galois_lfsr_gen: LFSR_WIDTH must be within 2..64");
  end
  if (K < 1 || K > LFSR_WIDTH) begin : g_bad_k
    $error("galois_lfsr_gen: LFSR_OUTPUT_BITS_PER_CLOCK must be within 1..LFSR_WIDTH");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("galois_lfsr_gen: LFSR_SEED must be non-zero");
  end

  logic [LFSR_WIDTH-1:0] state;
  logic [LFSR_WIDTH-1:0] step_next;
  logic [LFSR_WIDTH-1:0] seed_next;
  logic                  seed_is_zero;
  logic                  adv;

  galois_lfsr_step #(
    .WIDTH (LFSR_WIDTH),
    .POLY  (LFSR_POLY),
    .STEPS (K)
  ) u_step (
    .state      (state),
    .next_state (step_next)
  );

  assign seed_is_zero = (seed_value == '0);
  assign seed_next    = LFSR_WIDTH'(lfsr_safe_seed(LFSR_MAX_WIDTH'(seed_value),
                                                   LFSR_MAX_WIDTH'(LFSR_SEED)));
  // A new word is produced only when the output slot is free or being emptied.
  assign adv          = enable & (~lfsr_valid | lfsr_ready) & ~seed_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= LFSR_SEED;
      lfsr_out      <= '0;
      lfsr_valid    <= 1'b0;
      seed_zero_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      seed_zero_err <= seed_load & seed_is_zero;
      if (seed_load) begin
        // Reseeding flushes the pending word; lfsr_out keeps its last value.
        state      <= seed_next;
        lfsr_valid <= 1'b0;
      end else if (adv) begin
        lfsr_out   <= state[LFSR_WIDTH-1 -: K];
        lfsr_valid <= 1'b1;
        state      <= step_next;
      end else if (lfsr_valid && lfsr_ready) begin
        lfsr_valid <= 1'b0;
      end
    end
  end

`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
  logic [LFSR_WIDTH-1:0] last_seed;
  logic                  hit_seed;

  assign hit_seed = (step_next == last_seed);

  // Period is measured in advances from the most recently loaded seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_seed   <= LFSR_SEED;
      step_count  <= '0;
      period_wrap <= 1'b0;
    end else begin
      period_wrap <= adv & hit_seed;
      if (seed_load) begin
        last_seed  <= seed_next;
        step_count <= '0;
      end else if (adv) begin
        step_count <= hit_seed ? '0 : step_count + 1'b1;
      end
    end
  end
`else
  // Without the period counter the loaded seed need not be remembered.
`endif

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Self-checking bench for galois_lfsr_gen: K=1 and K=8 instances on shared stimulus,
// constant vector table plus a word scoreboard fed from a reference model.
module tb_galois_lfsr_gen;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       seed_load;
  logic [7:0] seed_value;
  logic       ready;

  logic       out1, valid1, err1;
  logic [7:0] out8;
  logic       valid8, err8;

`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
  logic [7:0] cnt1, cnt8, cnt2;
  logic       wrap1, wrap8, wrap2;
  logic [1:0] out2;
  logic       valid2, err2;
`endif

  galois_lfsr_gen #(.LFSR_WIDTH(8), .LFSR_OUTPUT_BITS_PER_CLOCK(1)) u_k1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_value(seed_value), .lfsr_out(out1), .lfsr_valid(valid1),
    .lfsr_ready(ready), .seed_zero_err(err1)
`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
    , .step_count(cnt1), .period_wrap(wrap1)
`endif
  );

  galois_lfsr_gen #(.LFSR_WIDTH(8), .LFSR_OUTPUT_BITS_PER_CLOCK(8)) u_k8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_value(seed_value), .lfsr_out(out8), .lfsr_valid(valid8),
    .lfsr_ready(ready), .seed_zero_err(err8)
`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
    , .step_count(cnt8), .period_wrap(wrap8)
`endif
  );

`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
  galois_lfsr_gen #(.LFSR_WIDTH(8), .LFSR_OUTPUT_BITS_PER_CLOCK(2)) u_k2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_value(seed_value), .lfsr_out(out2), .lfsr_valid(valid2),
    .lfsr_ready(ready), .seed_zero_err(err2),
    .step_count(cnt2), .period_wrap(wrap2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 = K=1 instance, index 1 = K=8 instance.
  logic [7:0] m_state [2];
  logic       m_valid [2];
  logic       m_zerr;
  int         kk [2] = '{1, 8};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  typedef struct {
    logic       enable;
    logic       ready;
    logic       exp_k1;
    logic [7:0] exp_state;
    logic [7:0] exp_k8;
    logic       chk_k8;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s, input int k);
    logic [7:0] r = s;
    for (int i = 0; i < k; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
    return r;
  endfunction

  function automatic logic [7:0] obs_out(input int d);
    return (d == 0) ? {7'b0, out1} : out8;
  endfunction

  function automatic logic obs_valid(input int d);
    return (d == 0) ? valid1 : valid8;
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] sb_front(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void sb_push(input int d, input logic [7:0] w);
    if (d == 0) q0.push_back(w); else q1.push_back(w);
  endfunction

  function automatic logic [7:0] sb_pop(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Advance one clock: model consumes/produces words, then DUT outputs are compared.
  task automatic tick();
    logic [7:0] w;
    logic       adv;
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d] && (ready || seed_load)) begin
        if (sb_size(d) == 0) begin
          check($sformatf("sb_underflow_k%0d", kk[d]), 1, 0);
        end else begin
          w = sb_pop(d);
          if (ready) check($sformatf("sb_transfer_k%0d", kk[d]), obs_out(d), w);
        end
      end
      adv = enable && (!m_valid[d] || ready) && !seed_load;
      if (seed_load) begin
        m_state[d] = (seed_value == 8'h00) ? 8'h01 : seed_value;
        m_valid[d] = 1'b0;
      end else if (adv) begin
        sb_push(d, (kk[d] == 1) ? {7'b0, m_state[d][7]} : m_state[d]);
        m_valid[d] = 1'b1;
        m_state[d] = mstep(m_state[d], kk[d]);
      end else if (m_valid[d] && ready) begin
        m_valid[d] = 1'b0;
      end
    end
    m_zerr = seed_load && (seed_value == 8'h00);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("valid_k%0d", kk[d]), obs_valid(d), m_valid[d]);
      if (m_valid[d] && sb_size(d) > 0)
        check($sformatf("held_word_k%0d", kk[d]), obs_out(d), sb_front(d));
    end
    check("zero_err_k1", err1, m_zerr);
    check("zero_err_k8", err8, m_zerr);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 8'h01;
      m_valid[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("rst_valid_k1", valid1, 0);
    check("rst_valid_k8", valid8, 0);
    check("rst_out_k1", out1, 0);
    check("rst_out_k8", out8, 0);
    check("rst_err", {err1, err8}, 0);
    check("rst_state_k1", u_k1.state, 8'h01);
    check("rst_state_k8", u_k8.state, 8'h01);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_table();
    seed_load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].enable;
      ready  = tbl[i].ready;
      tick();
      check($sformatf("tbl%0d_out_k1", i), out1, tbl[i].exp_k1);
      check($sformatf("tbl%0d_state_k1", i), u_k1.state, tbl[i].exp_state);
      check($sformatf("tbl%0d_valid_k1", i), valid1, 1);
      if (tbl[i].chk_k8) check($sformatf("tbl%0d_out_k8", i), out8, tbl[i].exp_k8);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h01, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h1D, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h08, 8'h4C, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h1D, 8'h00, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'h3A, 8'h00, 1'b0};

    reset_n    = 1'b0;
    enable     = 1'b0;
    seed_load  = 1'b0;
    seed_value = 8'h00;
    ready      = 1'b0;
    m_zerr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle cycle: nothing valid until enable rises.
    tick();
    check("idle_valid_k1", valid1, 0);

    // Reference sequence for K=1 and K=8, one word per clock.
    run_table();

    // Backpressure on the K=8 word 0x1D.
    seed_load = 1'b1; seed_value = 8'h01;
    tick();
    seed_load = 1'b0; enable = 1'b1; ready = 1'b1;
    tick();
    check("bp_first_k8", out8, 8'h01);
    tick();
    check("bp_word_k8", out8, 8'h1D);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) enable = 1'b0;
      tick();
      check($sformatf("bp_hold%0d_k8", i), out8, 8'h1D);
      check($sformatf("bp_state%0d_k8", i), u_k8.state, 8'h4C);
    end
    enable = 1'b1; ready = 1'b1;
    tick();
    check("bp_release_k8", out8, 8'h4C);
    check("bp_release_valid_k8", valid8, 1);

    // Zero reseed while a word is stalled: flush and substitute seed.
    ready = 1'b0;
    seed_load = 1'b1; seed_value = 8'h00;
    tick();
    check("zs_err_pulse", err1, 1);
    check("zs_flush_k8", valid8, 0);
    check("zs_state_k1", u_k1.state, 8'h01);
    check("zs_state_k8", u_k8.state, 8'h01);
    seed_load = 1'b0; enable = 1'b0;
    tick();
    check("zs_err_drop", err8, 0);
    run_table();

    // Reseed concurrent with a transfer: word consumed once, then A5 stream.
    enable = 1'b1; ready = 1'b1;
    seed_load = 1'b1; seed_value = 8'hA5;
    tick();
    check("sl_xfer_valid_k1", valid1, 0);
    seed_load = 1'b0;
    tick();
    check("sl_first_k1", out1, 1);
    check("sl_first_k8", out8, 8'hA5);

    // Randomised handshake and occasional reseeds against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 9) < 7);
      ready     = ($urandom_range(0, 9) < 6);
      seed_load = ($urandom_range(0, 99) < 3);
      seed_value = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tick();
    end
    seed_load = 1'b0; enable = 1'b0; ready = 1'b1;
    repeat (2) tick();
    check("sb_drained_k1", q0.size(), 0);
    check("sb_drained_k8", q1.size(), 0);

    // Reset with a stalled word pending.
    enable = 1'b1; ready = 1'b0;
    seed_load = 1'b1; seed_value = 8'h5A;
    tick();
    seed_load = 1'b0;
    tick();
    check("mid_pending_k8", valid8, 1);
    do_reset();
    seed_load = 1'b0; enable = 1'b0; ready = 1'b0;
    tick();
    check("post_rst_valid_k8", valid8, 0);

`ifdef GALOIS_LFSR_PERIOD_COUNT_EN
    do_reset();
    enable = 1'b1; ready = 1'b1; seed_load = 1'b0;
    for (int n = 1; n <= 255; n++) begin
      tick();
      if (n == 254) begin
        check("per_cnt254_k1", cnt1, 254);
        check("per_nowrap_k1", wrap1, 0);
        check("per_cnt254_k2", cnt2, 254);
        check("per_nowrap_k2", wrap2, 0);
      end
      if (n == 255) begin
        check("per_wrap_k1", wrap1, 1);
        check("per_cnt0_k1", cnt1, 0);
        check("per_wrap_k2", wrap2, 1);
        check("per_cnt0_k2", cnt2, 0);
      end
    end
    tick();
    check("per_wrap_pulse_k1", wrap1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
